// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, data and memory-side signals of the shared memory port.
// Latency: none, wires only.
// Backpressure: requesters hold req until done; stall_* tells the pipeline to wait.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    // data requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    // pipeline hazard outputs
    logic              stall_if;
    logic              stall_mem;
    // memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_done, if_rdata, dm_done, dm_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters plus memory
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and data accesses, data first, fetch starvation bounded.
// Latency: issue same cycle as grant; read done at issue+MEM_LAT, write done at issue+1.
// Backpressure: one transaction in flight; waiting requesters see stall_* until their done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [LAT_W-1:0] RD_LAT  = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [STV_W-1:0] STV_LIM = STV_W'(STARVE_MAX);
    localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic             owner_dm;   // 0 = fetch owns the port, 1 = data
    logic             op_we;

    logic grant_dm;
    logic grant_if;
    logic issue;
    logic done;
    logic issue_wr;

    // Same-cycle arbitration in IDLE: data wins unless fetch has waited STARVE_MAX data grants.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (!rst && state == ST_IDLE) begin
            if (bus.dm_req && (!bus.if_req || starve_cnt < STV_LIM)) begin
                grant_dm = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    assign issue    = grant_dm | grant_if;
    assign issue_wr = grant_dm & bus.dm_we;
    // Reset suppresses the done pulse so in-flight read data is dropped.
    assign done     = !rst && (state == ST_WAIT) && (lat_cnt == '0);

    // Memory strobe and payload only in the issue cycle; everything reads 0 otherwise.
    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue_wr;
    assign bus.mem_addr  = grant_dm ? bus.dm_addr : (grant_if ? bus.if_addr : '0);
    assign bus.mem_wdata = issue_wr ? bus.dm_wdata : '0;

    // Completion: read data is passed straight through from memory in the done cycle only.
    assign bus.if_done  = done & ~owner_dm;
    assign bus.dm_done  = done & owner_dm;
    assign bus.if_rdata = (done && !owner_dm && !op_we) ? bus.mem_rdata : '0;
    assign bus.dm_rdata = (done && owner_dm && !op_we) ? bus.mem_rdata : '0;

    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_done;

    // Transaction FSM: latch owner/op at issue, count down read latency, return to IDLE on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            owner_dm <= 1'b0;
            op_we    <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (issue) begin
                state    <= ST_WAIT;
                owner_dm <= grant_dm;
                op_we    <= issue_wr;
                lat_cnt  <= issue_wr ? '0 : RD_LAT;
            end
        end else begin
            if (lat_cnt == '0) begin
                state <= ST_IDLE;
            end else begin
                lat_cnt <= lat_cnt - LAT_ONE;
            end
        end
    end

    // Starvation counter: counts data grants taken while fetch was waiting, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_dm && bus.if_req) begin
            if (starve_cnt != STV_LIM) begin
                starve_cnt <= starve_cnt + STV_ONE;
            end
        end else if (issue) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed bench for the shared memory port arbiter with issue/response scoreboards.
// Latency: checks cycle-exact issue and done timing for MEM_LAT=2 and MEM_LAT=1 instances.
// Backpressure: requesters hold req until done, mirroring the pipeline's stall behaviour.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    iss_t        iss_q [$];
    logic [31:0] if_q  [$];
    logic [31:0] dm_q  [$];
    logic [31:0] b_q   [$];

    int          a_pend_cyc = -1;
    logic [31:0] a_pend_dat = '0;
    int          b_pend_cyc = -1;
    logic [31:0] b_pend_dat = '0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_rd(input logic [31:0] addr);
        return (addr == 32'h40) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory model: read data appears MEM_LAT cycles after the strobe, garbage otherwise.
    initial forever begin
        @(posedge clk);
        #1;
        bus_a.mem_rdata = (cyc == a_pend_cyc) ? a_pend_dat : {16'hBAD0, cyc[15:0]};
        bus_b.mem_rdata = (cyc == b_pend_cyc) ? b_pend_dat : {16'hBAD1, cyc[15:0]};
    end

    // Monitors: compare each memory issue and each done pulse against the scoreboards.
    initial forever begin
        iss_t e;
        @(negedge clk);
        if (bus_a.mem_en) begin
            if (!bus_a.mem_we) begin
                a_pend_cyc = cyc + 2;
                a_pend_dat = exp_rd(bus_a.mem_addr);
            end
            if (iss_q.size() == 0) begin
                chk("iss_spurious", 64'(1), 64'(0));
            end else begin
                e = iss_q.pop_front();
                chk("iss_we", 64'(bus_a.mem_we), 64'(e.we));
                chk("iss_addr", 64'(bus_a.mem_addr), 64'(e.addr));
                chk("iss_wdata", 64'(bus_a.mem_wdata), 64'(e.wdata));
            end
        end else begin
            chk("idle_mem_bus", 64'(|{bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}), 64'(0));
        end
        if (bus_a.if_done) begin
            if (if_q.size() == 0) chk("if_done_spurious", 64'(1), 64'(0));
            else chk("if_rdata", 64'(bus_a.if_rdata), 64'(if_q.pop_front()));
        end else begin
            chk("if_rdata_idle", 64'(bus_a.if_rdata), 64'(0));
        end
        if (bus_a.dm_done) begin
            if (dm_q.size() == 0) chk("dm_done_spurious", 64'(1), 64'(0));
            else chk("dm_rdata", 64'(bus_a.dm_rdata), 64'(dm_q.pop_front()));
        end else begin
            chk("dm_rdata_idle", 64'(bus_a.dm_rdata), 64'(0));
        end
        if (bus_b.mem_en && !bus_b.mem_we) begin
            b_pend_cyc = cyc + 1;
            b_pend_dat = exp_rd(bus_b.mem_addr);
        end
        if (bus_b.if_done) begin
            if (b_q.size() == 0) chk("b_if_done_spurious", 64'(1), 64'(0));
            else chk("b_if_rdata", 64'(bus_b.if_rdata), 64'(b_q.pop_front()));
        end
    end

    initial begin
        logic [2:0] exp_stv [6];
        logic       exp_if  [6];
        exp_stv = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        exp_if  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        bus_a.if_req = 1'b0; bus_a.if_addr = '0;
        bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0;
        bus_b.dm_req = 1'b0; bus_b.dm_we = 1'b0; bus_b.dm_addr = '0; bus_b.dm_wdata = '0;

        // reset state
        nxt(); nxt(); smp();
        chk("rst_mem_en", 64'(bus_a.mem_en), 64'(0));
        chk("rst_if_done", 64'(bus_a.if_done), 64'(0));
        chk("rst_state", 64'(dut_a.state), 64'(0));
        chk("rst_starve", 64'(dut_a.starve_cnt), 64'(0));
        nxt(); rst = 1'b0; smp();

        // single fetch read
        nxt();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h40;
        iss_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        if_q.push_back(exp_rd(32'h40));
        smp();
        chk("rd_issue", 64'(bus_a.mem_en), 64'(1));
        chk("rd_stall_c0", 64'(bus_a.stall_if), 64'(1));
        nxt(); smp();
        chk("rd_stall_c1", 64'(bus_a.stall_if), 64'(1));
        chk("rd_no_done_c1", 64'(bus_a.if_done), 64'(0));
        nxt(); smp();
        chk("rd_done_c2", 64'(bus_a.if_done), 64'(1));
        chk("rd_stall_c2", 64'(bus_a.stall_if), 64'(0));
        nxt(); bus_a.if_req = 1'b0; smp();
        chk("rd_idle", 64'(dut_a.state), 64'(0));

        // data write
        nxt();
        bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b1; bus_a.dm_addr = 32'h100; bus_a.dm_wdata = 32'h1234_5678;
        iss_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'h1234_5678});
        dm_q.push_back(32'h0);
        smp();
        chk("wr_issue", 64'(bus_a.mem_en), 64'(1));
        chk("wr_stall", 64'(bus_a.stall_mem), 64'(1));
        nxt(); smp();
        chk("wr_done", 64'(bus_a.dm_done), 64'(1));
        chk("wr_stall_done", 64'(bus_a.stall_mem), 64'(0));
        nxt(); bus_a.dm_req = 1'b0; bus_a.dm_we = 1'b0; smp();
        chk("wr_idle", 64'(dut_a.state), 64'(0));

        // simultaneous data read and fetch: data first, fetch right after
        nxt();
        bus_a.dm_req = 1'b1; bus_a.dm_addr = 32'h200;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h44;
        iss_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
        iss_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
        dm_q.push_back(exp_rd(32'h200));
        if_q.push_back(exp_rd(32'h44));
        smp(); chk("pri_stall_c0", 64'(bus_a.stall_if), 64'(1));
        nxt(); smp(); chk("pri_stall_c1", 64'(bus_a.stall_if), 64'(1));
        nxt(); smp();
        chk("pri_dm_done_c2", 64'(bus_a.dm_done), 64'(1));
        chk("pri_stall_c2", 64'(bus_a.stall_if), 64'(1));
        nxt(); bus_a.dm_req = 1'b0; smp();
        chk("pri_if_issue_c3", 64'(bus_a.mem_en), 64'(1));
        chk("pri_stall_c3", 64'(bus_a.stall_if), 64'(1));
        nxt(); smp(); chk("pri_stall_c4", 64'(bus_a.stall_if), 64'(1));
        nxt(); smp();
        chk("pri_if_done_c5", 64'(bus_a.if_done), 64'(1));
        chk("pri_stall_c5", 64'(bus_a.stall_if), 64'(0));
        nxt(); bus_a.if_req = 1'b0; smp();

        // contention with both requests held: DM x4, IF, DM
        for (int k = 0; k < 6; k++) begin
            if (exp_if[k]) begin
                iss_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
                if_q.push_back(exp_rd(32'h80));
            end else begin
                iss_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
                dm_q.push_back(exp_rd(32'h300));
            end
        end
        for (int k = 0; k < 6; k++) begin
            nxt();
            if (k == 0) begin
                bus_a.dm_req = 1'b1; bus_a.dm_we = 1'b0; bus_a.dm_addr = 32'h300;
                bus_a.if_req = 1'b1; bus_a.if_addr = 32'h80;
            end
            smp(); chk($sformatf("cont_issue_%0d", k), 64'(bus_a.mem_en), 64'(1));
            nxt(); smp(); chk($sformatf("cont_starve_%0d", k), 64'(dut_a.starve_cnt), 64'(exp_stv[k]));
            nxt(); smp();
            chk($sformatf("cont_if_done_%0d", k), 64'(bus_a.if_done), 64'(exp_if[k]));
            chk($sformatf("cont_dm_done_%0d", k), 64'(bus_a.dm_done), 64'(!exp_if[k]));
        end
        nxt(); bus_a.dm_req = 1'b0; bus_a.if_req = 1'b0; smp();
        chk("cont_quiet", 64'(bus_a.mem_en), 64'(0));

        // reset in the middle of a read
        nxt();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h48;
        iss_q.push_back('{we: 1'b0, addr: 32'h48, wdata: 32'h0});
        smp();
        nxt(); rst = 1'b1; smp();
        nxt(); rst = 1'b0; bus_a.if_req = 1'b0; smp();
        chk("mr_no_done", 64'(bus_a.if_done), 64'(0));
        chk("mr_rdata", 64'(bus_a.if_rdata), 64'(0));
        chk("mr_mem_en", 64'(bus_a.mem_en), 64'(0));
        chk("mr_state", 64'(dut_a.state), 64'(0));
        chk("mr_starve", 64'(dut_a.starve_cnt), 64'(0));
        nxt();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h4C;
        iss_q.push_back('{we: 1'b0, addr: 32'h4C, wdata: 32'h0});
        if_q.push_back(exp_rd(32'h4C));
        smp(); chk("mr_regrant", 64'(bus_a.mem_en), 64'(1));
        nxt(); smp();
        nxt(); smp(); chk("mr_done", 64'(bus_a.if_done), 64'(1));
        nxt(); bus_a.if_req = 1'b0; smp();

        // MEM_LAT=1 back-to-back fetches
        nxt();
        bus_b.if_req = 1'b1; bus_b.if_addr = 32'h0;
        b_q.push_back(exp_rd(32'h0));
        smp();
        chk("b_en_c0", 64'(bus_b.mem_en), 64'(1));
        chk("b_addr_c0", 64'(bus_b.mem_addr), 64'(0));
        chk("b_done_c0", 64'(bus_b.if_done), 64'(0));
        nxt(); smp();
        chk("b_en_c1", 64'(bus_b.mem_en), 64'(0));
        chk("b_done_c1", 64'(bus_b.if_done), 64'(1));
        nxt();
        bus_b.if_addr = 32'h4;
        b_q.push_back(exp_rd(32'h4));
        smp();
        chk("b_en_c2", 64'(bus_b.mem_en), 64'(1));
        chk("b_addr_c2", 64'(bus_b.mem_addr), 64'(4));
        chk("b_done_c2", 64'(bus_b.if_done), 64'(0));
        nxt(); smp();
        chk("b_done_c3", 64'(bus_b.if_done), 64'(1));
        nxt(); bus_b.if_req = 1'b0; smp();
        chk("b_en_c4", 64'(bus_b.mem_en), 64'(0));
        chk("b_done_c4", 64'(bus_b.if_done), 64'(0));

        // every expected transaction must have been observed
        nxt(); smp();
        chk("iss_q_left", 64'(iss_q.size()), 64'(0));
        chk("if_q_left", 64'(if_q.size()), 64'(0));
        chk("dm_q_left", 64'(dm_q.size()), 64'(0));
        chk("b_q_left", 64'(b_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between instruction fetch and data accesses (LDM reads, STM writes) of the core.
- Data requests come from the MEM stage, driven by the decoded mem_write and the LDM result select. Fetch requests come from the IF stage.
- Allows one outstanding transaction, with data priority and a bounded fetch-starvation counter.
- Produces per-requester stall signals consumed by the pipeline hazard logic.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, read latency of memory in cycles (>=1)
- STARVE_MAX, 4, maximum consecutive data grants while fetch waits (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- if_req  input  1  fetch request (level, held until if_done)
- if_addr  input  ADDR_W  fetch address, stable while if_req
- if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  output  DATA_W  fetched instruction
- dm_req  input  1  data request (level, held until dm_done)
- dm_we  input  1  1 = STM write, 0 = LDM read; stable while dm_req
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_done  output  1  one-cycle pulse: data access complete
- dm_rdata  output  DATA_W  load data, valid with dm_done when dm_we=0
- stall_if  output  1  if_req & ~if_done
- stall_mem  output  1  dm_req & ~dm_done
- mem_en  output  1  memory access strobe, exactly one cycle per transaction
- mem_we  output  1  write enable, qualified by mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  read data, valid MEM_LAT cycles after mem_en

Behaviour:
- FSM states:
  - IDLE: no transaction in flight.
  - WAIT: transaction in flight; holds owner (IF/DM), op (read/write) and down-counter lat_cnt.
- IDLE arbitration is combinational, same cycle:
  - If dm_req and (~if_req or starve_cnt<STARVE_MAX): grant DM.
  - Else if if_req: grant IF.
  - Else: no grant.
- Issue cycle T (grant in IDLE):
  - mem_en=1; mem_addr, mem_we, mem_wdata come from the owner (fetch: mem_we=0, mem_wdata=0).
  - Next state WAIT, owner latched.
  - lat_cnt loads MEM_LAT-1 for reads, 0 for writes.
- mem_* outputs: mem_en=0 in every non-issue cycle; mem_addr/mem_we/mem_wdata are 0 when mem_en=0.
- WAIT:
  - While lat_cnt>0: decrement.
  - At lat_cnt==0, done cycle:
    - Pulse owner's done.
    - Reads: rdata = mem_rdata, passed combinationally, valid only in the done cycle. Otherwise rdata outputs are 0.
    - Next state IDLE.
- Latency:
  - Read done at T+MEM_LAT.
  - Write done at T+1.
  - Next grant is possible at done+1, giving back-to-back throughput of one transaction per MEM_LAT+1 cycles (reads).
- Requester rule: req must be low in the cycle after done unless a new transaction is intended. A still-high req is treated as a new request.
- Starvation counter starve_cnt, width clog2(STARVE_MAX+1), reset 0:
  - DM grant while if_req=1: saturating increment.
  - IF grant, or DM grant with if_req=0: clear to 0.
- Simultaneous if_req & dm_req in IDLE with starve_cnt==STARVE_MAX: IF wins; counter clears.
- Requests arriving during WAIT: not granted; their stall stays high until serviced.
- A request dropped before grant is legal and leaves no effect. A request dropped after grant is illegal; the transaction still completes and done still pulses.
- Reset, including mid-WAIT:
  - Next state IDLE; lat_cnt=0, starve_cnt=0, owner=IF.
  - All outputs 0 (mem_en, if_done, dm_done, rdata, mem_*).
  - In-flight read data is discarded and no done is pulsed.
  - The memory-side write already issued is not retracted.
- stall_if and stall_mem are combinational from req/done and need no extra state.

Test Plan:
- Single read, MEM_LAT=2: if_req=1, if_addr=0x40 at cycle 0 → mem_en=1, addr=0x40 at cycle 0. mem_rdata=0xDEADBEEF at cycle 2 → if_done=1, if_rdata=0xDEADBEEF at cycle 2. stall_if=1 at cycles 0–1, 0 at cycle 2.
- Write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 → mem_en=1, mem_we=1 with those values at T; dm_done at T+1; IDLE at T+2.
- Contention: if_req and dm_req both held and re-raised after each done, STARVE_MAX=4 → grant order DM,DM,DM,DM,IF,DM…; starve_cnt reads 1,2,3,4,0.
- Data priority without starvation: dm_req (read 0x200) and if_req raised together at cycle 0 → DM issued at 0 and done at 2; IF issued at 3 and done at 5. stall_if stays high over cycles 0–4.
- Reset mid-read: issue read at T, rst=1 at T+1 → no done pulse at T+2. All outputs 0 at T+2, FSM in IDLE. A fresh if_req at T+3 is granted at T+3.
- MEM_LAT=1 back-to-back reads: fetch at 0x0 then 0x4 → mem_en at cycles 0 and 2, if_done at cycles 1 and 3.
